// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - MEM-stage request/response bundle for data_mem_ctrl
//
// Purpose: groups the EX/MEM request qualifiers and the load/stall/complete
// responses of the data-memory responder into one port.
// Signals:
//   MemRead_i   load request from EX/MEM
//   MemWrite_i  store request from EX/MEM (wins when both are high)
//   funct3_i    access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i      byte address (ALU result)
//   wdata_i     store data (rs2)
//   rdata_o     formatted load data
//   stall_o     hold IF/ID/EX/MEM pipeline registers
//   done_o      one-cycle access-complete pulse
//   err_o       one-cycle misaligned/illegal-funct3 pulse
interface data_mem_ctrl_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  // Pipeline side: issues requests, observes responses.
  modport master (
    output MemRead_i, MemWrite_i, funct3_i, addr_i, wdata_i,
    input  rdata_o, stall_o, done_o, err_o
  );

  // Memory side: observes requests, drives responses.
  modport slave (
    input  MemRead_i, MemWrite_i, funct3_i, addr_i, wdata_i,
    output rdata_o, stall_o, done_o, err_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I MEM-stage data memory responder with wait states
//
// Purpose: performs byte/half/word loads and stores on an internal
// word-organised memory, stalling the pipeline for WAIT_STATES+1 cycles per
// access and returning sign/zero-extended load data.
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra BUSY cycles per access (0..15)
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      data_mem_ctrl_if.slave request/response bundle
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  data_mem_ctrl_if.slave  bus
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic          r_is_store;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_legal;
  logic          w_start;
  logic          w_err;
  logic          w_stall;
  logic          w_done;
  logic          w_do_access;
  logic [AW+1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [2:0]    w_acc_funct3;
  logic          w_acc_store;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_wr_data;
  logic [3:0]    w_be;
  logic          w_unused_addr;

  // Upper address bits alias onto the same words.
  assign w_unused_addr = ^bus.addr_i[31:AW+2];

  assign w_req = bus.MemRead_i | bus.MemWrite_i;

  // Alignment and funct3 legality of the request presented in IDLE.
  // A simultaneous read+write is a store, so it follows store rules.
  always_comb begin
    w_legal = 1'b0;
    case (bus.funct3_i)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~bus.addr_i[0];
      3'b010:  w_legal = (bus.addr_i[1:0] == 2'b00);
      3'b100:  w_legal = ~bus.MemWrite_i;
      3'b101:  w_legal = ~bus.MemWrite_i & ~bus.addr_i[0];
      default: w_legal = 1'b0;
    endcase
  end

  assign w_start = (r_state == IDLE) & w_req & w_legal;

  // With zero wait states the access happens on the accepting edge, so the
  // live inputs are used; otherwise the latched copy drives the access.
  assign w_acc_addr   = (r_state == IDLE) ? bus.addr_i[AW+1:0] : r_addr;
  assign w_acc_wdata  = (r_state == IDLE) ? bus.wdata_i        : r_wdata;
  assign w_acc_funct3 = (r_state == IDLE) ? bus.funct3_i       : r_funct3;
  assign w_acc_store  = (r_state == IDLE) ? bus.MemWrite_i     : r_is_store;

  // Gating with rst_n_i keeps a reset asserted across a clock edge from
  // committing a pending store into the (unreset) memory.
  assign w_do_access = rst_n_i &
                       ((w_start & (WAIT_STATES == 0)) |
                        ((r_state == BUSY) & (r_cnt == 4'd1)));

  assign w_idx  = w_acc_addr[AW+1:2];
  assign w_lane = w_acc_addr[1:0];

  // FSM next state and pipeline-facing outputs.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_start;
        w_err   = w_req & ~w_legal;
        if (w_start) begin
          w_next = (WAIT_STATES == 0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd1) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt      <= WS;
        r_addr     <= bus.addr_i[AW+1:0];
        r_wdata    <= bus.wdata_i;
        r_funct3   <= bus.funct3_i;
        r_is_store <= bus.MemWrite_i;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Store lane selection; data is replicated so each lane sees its slice.
  always_comb begin
    w_be      = 4'b0000;
    w_wr_data = w_acc_wdata;
    case (w_acc_funct3[1:0])
      2'b00: begin
        w_be      = 4'b0001 << w_lane;
        w_wr_data = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{w_acc_wdata[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wr_data = w_acc_wdata;
      end
    endcase
  end

  // Memory contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_do_access && w_acc_store) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_lane +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = w_word;
    case (w_acc_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end

  // Load data holds until the next completed load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rdata <= 32'd0;
    end else if (w_do_access && !w_acc_store) begin
      r_rdata <= w_load;
    end
  end

  assign bus.rdata_o = r_rdata;
  assign bus.stall_o = w_stall;
  assign bus.done_o  = w_done;
  assign bus.err_o   = w_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed table-driven bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic clk;
  logic rst_n;

  data_mem_ctrl_if bus2();
  data_mem_ctrl_if bus0();

  data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus2)
  );

  data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;        // 0: WAIT_STATES=2 instance, 1: WAIT_STATES=0
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input bit sel, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input bit exp_err);
    vec_t v;
    v.sel = sel; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_stall = exp_err ? 0 : (sel ? 1 : 3);
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus2.MemRead_i  = sel ? 1'b0 : rd;
    bus2.MemWrite_i = sel ? 1'b0 : wr;
    bus0.MemRead_i  = sel ? rd : 1'b0;
    bus0.MemWrite_i = sel ? wr : 1'b0;
    bus2.funct3_i = f3; bus2.addr_i = a; bus2.wdata_i = wd;
    bus0.funct3_i = f3; bus0.addr_i = a; bus0.wdata_i = wd;
  endtask

  task automatic sample(input bit sel, output logic st, output logic dn,
                        output logic er, output logic [31:0] rd);
    st = sel ? bus0.stall_o : bus2.stall_o;
    dn = sel ? bus0.done_o  : bus2.done_o;
    er = sel ? bus0.err_o   : bus2.err_o;
    rd = sel ? bus0.rdata_o : bus2.rdata_o;
  endtask

  // Presents one request for a single cycle, then watches a fixed window.
  task automatic run_vec(input vec_t v, input int idx);
    int          stalls, done_cyc, done_cnt, err_cnt, overlap;
    logic        st, dn, er;
    logic [31:0] rd;
    stalls = 0; done_cyc = -1; done_cnt = 0; err_cnt = 0; overlap = 0;
    @(posedge clk); #1;
    drive(v.sel, v.rd, v.wr, v.f3, v.addr, v.wdata);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sample(v.sel, st, dn, er, rd);
      if (st) stalls++;
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (er) err_cnt++;
      if (dn && (er || st)) overlap++;
      if (c == 0) begin
        @(posedge clk); #1;
        drive(v.sel, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      end
    end
    check($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
    check($sformatf("v%0d done_count", idx), 32'(done_cnt), v.exp_err ? 32'd0 : 32'd1);
    check($sformatf("v%0d done_cycle", idx), 32'(done_cyc),
          v.exp_err ? 32'hFFFF_FFFF : 32'(v.exp_stall));
    check($sformatf("v%0d err_count", idx), 32'(err_cnt), v.exp_err ? 32'd1 : 32'd0);
    check($sformatf("v%0d done_overlap", idx), 32'(overlap), 32'd0);
    check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
  endtask

  initial begin
    logic        st, dn, er;
    logic [31:0] rd;
    vec_t        v;
    n_tests = 0;
    n_fail  = 0;

    // WAIT_STATES=2 instance
    add(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 0); // SW
    add(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0); // LW
    add(0, 0, 1, 3'b000, 32'h13, 32'h12345680, 32'hDEADBEEF, 0); // SB
    add(0, 1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0); // LB
    add(0, 1, 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 0); // LBU
    add(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0); // LW
    add(0, 0, 1, 3'b001, 32'h12, 32'hCAFE8001, 32'h80ADBEEF, 0); // SH
    add(0, 1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 0); // LH
    add(0, 1, 0, 3'b101, 32'h12, 32'h0,        32'h00008001, 0); // LHU
    add(0, 1, 0, 3'b001, 32'h11, 32'h0,        32'h00008001, 1); // LH misaligned
    add(0, 0, 1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h00008001, 1); // SW misaligned
    add(0, 1, 0, 3'b011, 32'h10, 32'h0,        32'h00008001, 1); // bad load funct3
    add(0, 0, 1, 3'b100, 32'h10, 32'h0,        32'h00008001, 1); // SBU illegal
    add(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'h8001BEEF, 0); // LW
    add(0, 1, 0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 0); // LB
    add(0, 1, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0); // LHU
    add(0, 1, 1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0000BEEF, 0); // read+write = store
    add(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 0); // LW
    add(0, 0, 1, 3'b000, 32'h21, 32'h0000007F, 32'hA5A5A5A5, 0); // SB
    add(0, 1, 0, 3'b000, 32'h21, 32'h0,        32'h0000007F, 0); // LB positive
    add(0, 1, 0, 3'b001, 32'h22, 32'h0,        32'hFFFFA5A5, 0); // LH upper half
    add(0, 0, 1, 3'b010, 32'h30, 32'h0BADF00D, 32'hFFFFA5A5, 0); // SW
    // WAIT_STATES=0 instance
    add(1, 0, 1, 3'b010, 32'h0,   32'h12345678, 32'h00000000, 0); // SW
    add(1, 1, 0, 3'b010, 32'h400, 32'h0,        32'h12345678, 0); // LW alias
    add(1, 1, 0, 3'b000, 32'h401, 32'h0,        32'h00000056, 0); // LB alias
    add(1, 1, 0, 3'b101, 32'h402, 32'h0,        32'h00001234, 0); // LHU
    add(1, 1, 0, 3'b010, 32'h2,   32'h0,        32'h00001234, 1); // LW misaligned

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], st, dn, er, rd);
      check($sformatf("reset%0d stall", s), {31'd0, st}, 32'd0);
      check($sformatf("reset%0d done", s),  {31'd0, dn}, 32'd0);
      check($sformatf("reset%0d err", s),   {31'd0, er}, 32'd0);
      check($sformatf("reset%0d rdata", s), rd, 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted in the second BUSY cycle of a pending store.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h11111111);
    @(negedge clk);
    check("rst_seq idle_stall", {31'd0, bus2.stall_o}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(posedge clk); #2;
    check("rst_seq busy2_stall", {31'd0, bus2.stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_seq async_stall", {31'd0, bus2.stall_o}, 32'd0);
    check("rst_seq async_done",  {31'd0, bus2.done_o},  32'd0);
    check("rst_seq async_err",   {31'd0, bus2.err_o},   32'd0);
    check("rst_seq async_rdata", bus2.rdata_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_seq post_stall", {31'd0, bus2.stall_o}, 32'd0);
    check("rst_seq post_done",  {31'd0, bus2.done_o},  32'd0);
    v.sel = 0; v.rd = 1; v.wr = 0; v.f3 = 3'b010; v.addr = 32'h30; v.wdata = 32'd0;
    v.exp_rdata = 32'h0BADF00D; v.exp_err = 0; v.exp_stall = 3;
    run_vec(v, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
